// File: rtl/router_pkg.sv
// Shared definitions for the NUM_PORTS router controller: state encoding and
// the default port/address geometry.
package router_pkg;

   localparam int RTR_NUM_PORTS = 3;
   localparam int RTR_ADDR_W    = 2;

   typedef enum logic [3:0] {
      DECODE_ADDRESS     = 4'h1,
      LOAD_FIRST_DATA    = 4'h2,
      LOAD_DATA          = 4'h3,
      WAIT_TILL_EMPTY    = 4'h4,
      FIFO_FULL_STATE    = 4'h5,
      LOAD_AFTER_FULL    = 4'h6,
      LOAD_PARITY        = 4'h7,
      CHECK_PARITY_ERROR = 4'h8,
      DROP_PACKET        = 4'h9
   } state_t;

endpackage

// File: rtl/router_sat_counter.sv
// Saturating up-counter with enable and synchronous clear.
module router_sat_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             enable,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clock) begin
      if (clear)
         count <= '0;
      else if (enable && (count != '1))
         count <= count + CNT_W'(1);
   end

endmodule

// File: rtl/router_fsm_np.sv
// Router control FSM for NUM_PORTS destination FIFOs, with invalid-address and
// wait-timeout packet dropping plus a saturating drop counter.
module router_fsm_np
   import router_pkg::*;
#(
   parameter int NUM_PORTS = RTR_NUM_PORTS,
   parameter int ADDR_W    = RTR_ADDR_W,
   parameter int WAIT_MAX  = 64,
   parameter int CNT_W     = 8
) (
   input  logic                 clock,
   input  logic                 resetn,
   input  logic                 pkt_valid,
   input  logic [ADDR_W-1:0]    data_in,
   input  logic                 parity_done,
   input  logic                 low_pkt_valid,
   input  logic                 fifo_full,
   input  logic [NUM_PORTS-1:0] fifo_empty,
   input  logic [NUM_PORTS-1:0] soft_reset,
   output logic                 busy,
   output logic                 detect_add,
   output logic                 lfd_state,
   output logic                 ld_state,
   output logic                 laf_state,
   output logic                 full_state,
   output logic                 write_enb_reg,
   output logic                 rst_int_reg,
   output logic                 drop_state,
   output logic [ADDR_W-1:0]    dest_addr,
   output logic                 drop_pulse,
   output logic [CNT_W-1:0]     drop_count
);

   localparam int WC_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

   state_t              state, next_state;
   logic [WC_W-1:0]     wait_cnt;
   logic [2**ADDR_W-1:0] empty_ext, sr_ext;
   logic                hdr_ok, timeout, drop_enter;

   // Pad per-port flags to the full address space so any address indexes safely.
   always_comb begin
      empty_ext = '0;
      sr_ext    = '0;
      empty_ext[NUM_PORTS-1:0] = fifo_empty;
      sr_ext[NUM_PORTS-1:0]    = soft_reset;
   end

   assign hdr_ok  = (int'(data_in) < NUM_PORTS);
   assign timeout = (WAIT_MAX != 0) && (wait_cnt == WC_W'(WAIT_MAX - 1));

   always_comb begin
      next_state = state;
      unique case (state)
         DECODE_ADDRESS: begin
            if (pkt_valid) begin
               if (!hdr_ok)
                  next_state = DROP_PACKET;
               else if (empty_ext[data_in])
                  next_state = LOAD_FIRST_DATA;
               else
                  next_state = WAIT_TILL_EMPTY;
            end
         end
         WAIT_TILL_EMPTY: begin
            if (empty_ext[dest_addr])
               next_state = LOAD_FIRST_DATA;
            else if (timeout)
               next_state = DROP_PACKET;
         end
         LOAD_FIRST_DATA: next_state = LOAD_DATA;
         LOAD_DATA: begin
            if (fifo_full)
               next_state = FIFO_FULL_STATE;
            else if (!pkt_valid)
               next_state = LOAD_PARITY;
         end
         FIFO_FULL_STATE: begin
            if (!fifo_full)
               next_state = LOAD_AFTER_FULL;
         end
         LOAD_AFTER_FULL: begin
            if (parity_done)
               next_state = DECODE_ADDRESS;
            else if (low_pkt_valid)
               next_state = LOAD_PARITY;
            else
               next_state = LOAD_DATA;
         end
         LOAD_PARITY: next_state = CHECK_PARITY_ERROR;
         CHECK_PARITY_ERROR: begin
            if (fifo_full)
               next_state = FIFO_FULL_STATE;
            else
               next_state = DECODE_ADDRESS;
         end
         DROP_PACKET: begin
            if (!pkt_valid)
               next_state = DECODE_ADDRESS;
         end
         default: next_state = DECODE_ADDRESS;
      endcase
      if (sr_ext[dest_addr] && (state != DECODE_ADDRESS) && (state != DROP_PACKET))
         next_state = DECODE_ADDRESS;
   end

   assign drop_enter = (next_state == DROP_PACKET) && (state != DROP_PACKET);

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state      <= DECODE_ADDRESS;
         dest_addr  <= '0;
         wait_cnt   <= '0;
         drop_pulse <= 1'b0;
      end else begin
         state      <= next_state;
         drop_pulse <= drop_enter;
         if (state == DECODE_ADDRESS && pkt_valid)
            dest_addr <= data_in;
         // Counter only advances while remaining in WAIT; any entry/exit zeroes it.
         if (state == WAIT_TILL_EMPTY && next_state == WAIT_TILL_EMPTY)
            wait_cnt <= wait_cnt + WC_W'(1);
         else
            wait_cnt <= '0;
      end
   end

   router_sat_counter #(.CNT_W(CNT_W)) u_drop_cnt (
      .clock  (clock),
      .clear  (!resetn),
      .enable (drop_enter),
      .count  (drop_count)
   );

   assign detect_add    = (state == DECODE_ADDRESS);
   assign lfd_state     = (state == LOAD_FIRST_DATA);
   assign ld_state      = (state == LOAD_DATA);
   assign laf_state     = (state == LOAD_AFTER_FULL);
   assign full_state    = (state == FIFO_FULL_STATE);
   assign rst_int_reg   = (state == CHECK_PARITY_ERROR);
   assign drop_state    = (state == DROP_PACKET);
   assign write_enb_reg = (state == LOAD_DATA) || (state == LOAD_AFTER_FULL) ||
                          (state == LOAD_PARITY);
   assign busy          = (state == LOAD_FIRST_DATA) || (state == LOAD_PARITY) ||
                          (state == FIFO_FULL_STATE) || (state == LOAD_AFTER_FULL) ||
                          (state == WAIT_TILL_EMPTY) || (state == CHECK_PARITY_ERROR);

endmodule

// File: doc/router_fsm_np.md
Name: router_fsm_np

Overview:
- Next-generation router control FSM, generalised to NUM_PORTS destinations with a parametric address field.
- Sits between the input register block and the per-port FIFOs, like the current 3-port controller; drives the same load, busy and parity strobes.
- New behaviour:
  - drops packets whose address is invalid (address >= NUM_PORTS);
  - drops packets after a bounded WAIT_TILL_EMPTY timeout;
  - counts dropped packets in a saturating counter.

Parameters:
- NUM_PORTS, 3, number of destination FIFOs; legal range 2..(2**ADDR_W).
- ADDR_W, 2, header address field width (data_in[ADDR_W-1:0]).
- WAIT_MAX, 64, max cycles in WAIT_TILL_EMPTY before drop; 0 disables the timeout.
- CNT_W, 8, width of the drop counter.

Ports:
- clock  input  1  clock
- resetn  input  1  reset, synchronous, active-low
- pkt_valid  input  1  packet byte valid from source
- data_in  input  ADDR_W  header address bits of current byte
- parity_done  input  1  parity byte written (from register block)
- low_pkt_valid  input  1  pkt_valid fell while in full handling
- fifo_full  input  1  full flag of the selected FIFO (muxed externally)
- fifo_empty  input  NUM_PORTS  per-port FIFO empty flags
- soft_reset  input  NUM_PORTS  per-port soft reset (read timeout)
- busy, detect_add, lfd_state, ld_state, laf_state, full_state, write_enb_reg, rst_int_reg  output  1 each  state strobes
- drop_state  output  1  FSM in DROP_PACKET
- dest_addr  output  ADDR_W  latched destination address
- drop_pulse  output  1  one-cycle pulse on entry to DROP_PACKET
- drop_count  output  CNT_W  saturating count of dropped packets

Behaviour:
- Reset (resetn=0 at posedge): state=DECODE_ADDRESS, dest_addr=0, wait counter=0, drop_count=0, drop_pulse=0. After reset, detect_add=1 and all other strobes are 0.
- Address latch: dest_addr <= data_in only when state=DECODE_ADDRESS and pkt_valid=1.
- Valid header: hdr_ok = (data_in < NUM_PORTS).
- DECODE_ADDRESS:
  - pkt_valid & hdr_ok & fifo_empty[data_in] -> LOAD_FIRST_DATA.
  - pkt_valid & hdr_ok & !fifo_empty[data_in] -> WAIT_TILL_EMPTY.
  - pkt_valid & !hdr_ok -> DROP_PACKET.
  - Otherwise stay.
- WAIT_TILL_EMPTY:
  - wait counter increments each cycle; it is cleared on entry and on exit.
  - fifo_empty[dest_addr] -> LOAD_FIRST_DATA. This takes priority over the timeout when both occur in the same cycle.
  - Else if WAIT_MAX!=0 and counter==WAIT_MAX-1 -> DROP_PACKET.
  - Otherwise stay.
- LOAD_FIRST_DATA -> LOAD_DATA, unconditionally.
- LOAD_DATA:
  - fifo_full -> FIFO_FULL_STATE.
  - Else !pkt_valid -> LOAD_PARITY.
  - Otherwise stay.
- FIFO_FULL_STATE: fifo_full -> stay; else -> LOAD_AFTER_FULL.
- LOAD_AFTER_FULL:
  - parity_done -> DECODE_ADDRESS.
  - Else low_pkt_valid -> LOAD_PARITY.
  - Else -> LOAD_DATA.
- LOAD_PARITY -> CHECK_PARITY_ERROR.
- CHECK_PARITY_ERROR: fifo_full -> FIFO_FULL_STATE; else -> DECODE_ADDRESS.
- DROP_PACKET:
  - Stay while pkt_valid=1; pkt_valid=0 -> DECODE_ADDRESS.
  - The parity byte, presented with pkt_valid=0, is discarded.
- Soft reset: if soft_reset[dest_addr]=1 and state is not DECODE_ADDRESS or DROP_PACKET, next state is DECODE_ADDRESS. This overrides all transitions and clears the wait counter. Soft resets on other ports are ignored.
- Moore outputs, decoded from the current state:
  - detect_add = DECODE_ADDRESS.
  - lfd_state = LOAD_FIRST_DATA.
  - ld_state = LOAD_DATA.
  - laf_state = LOAD_AFTER_FULL.
  - full_state = FIFO_FULL_STATE.
  - rst_int_reg = CHECK_PARITY_ERROR.
  - drop_state = DROP_PACKET.
  - write_enb_reg = LOAD_DATA | LOAD_AFTER_FULL | LOAD_PARITY. It is 0 in DROP_PACKET.
  - busy = LOAD_FIRST_DATA | LOAD_PARITY | FIFO_FULL_STATE | LOAD_AFTER_FULL | WAIT_TILL_EMPTY | CHECK_PARITY_ERROR. busy is 0 in DROP_PACKET so the source streams bytes that are discarded.
- drop_pulse: registered, high for exactly the first cycle in DROP_PACKET.
- drop_count: +1 on the same edge drop_pulse is set; saturates at 2**CNT_W-1, no wrap.

Decomposition:
- Shared package router_pkg holds:
  - the state typedef/localparams: DECODE_ADDRESS=4'h1 through CHECK_PARITY_ERROR=4'h8, plus DROP_PACKET=4'h9;
  - the default NUM_PORTS and ADDR_W.
- One sub-module: router_sat_counter (CNT_W, saturating, enable, synchronous clear). Used for drop_count; the wait counter stays inline.

Test Plan:
- Header addr=1, fifo_empty=3'b111, 4 payload bytes, then parity -> state sequence DECODE -> LFD -> LD x4 -> LOAD_PARITY -> CHECK_PARITY -> DECODE; write_enb_reg high 5 cycles; drop_count=0.
- Header addr=3 with NUM_PORTS=3, pkt_valid high 5 cycles -> DROP_PACKET next cycle; drop_pulse 1 cycle; busy=0, write_enb_reg=0 throughout; back to DECODE when pkt_valid=0; drop_count=1.
- Header addr=2, fifo_empty[2]=0 held, WAIT_MAX=4 -> WAIT_TILL_EMPTY for exactly 4 cycles, then DROP_PACKET; drop_count increments.
- Same as above, but fifo_empty[2] rises on the 4th wait cycle -> LOAD_FIRST_DATA, no drop.
- fifo_full asserted for 3 cycles in LOAD_DATA, then parity_done=1 in LOAD_AFTER_FULL -> FIFO_FULL_STATE x3, LOAD_AFTER_FULL, DECODE.
- soft_reset[0] pulsed mid-LOAD_DATA with dest_addr=1 -> ignored. soft_reset[1] pulsed -> DECODE_ADDRESS next cycle. Force 256 drops with CNT_W=8 -> drop_count holds at 255.
